// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_ctrl
// Brief   : Run/stop/lap/clear controller for the 4-digit stopwatch chain.
// Rev     : 1.0  initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int DB_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic [3:0] cnt0,
  input  logic [3:0] cnt1,
  input  logic [3:0] cnt2,
  input  logic [3:0] cnt3,
  output logic       cin0,
  output logic       cnt_rst,
  output logic [3:0] disp0,
  output logic [3:0] disp1,
  output logic [3:0] disp2,
  output logic [3:0] disp3,
  output logic       run_led,
  output logic       lap_led,
  output logic       ovf_led
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0] c_pre_last = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] c_db_last  = DW'(DB_CYCLES - 1);
  localparam logic [15:0]   c_cnt_max  = 16'hF999;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVF   = 3'd4
  } state_e;

  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_clr, btn_lap, btn_ss};

  // Index 0 = start/stop, 1 = lap, 2 = clear.
  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_prev_q;
    logic [DW-1:0] db_cnt_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        meta_q       <= 1'b0;
        sync_q       <= 1'b0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        db_cnt_q     <= '0;
      end else begin
        meta_q       <= btn_raw[b];
        sync_q       <= meta_q;
        level_prev_q <= level_q;
        if (sync_q == level_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == c_db_last) begin
          level_q  <= sync_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end
    end

    assign press[b] = level_q & ~level_prev_q;
  end

  logic p_ss;
  logic p_lap;
  logic p_clr;

  assign p_clr = press[2];
  assign p_ss  = press[0] & ~press[2];
  assign p_lap = press[1] & ~press[0] & ~press[2];

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   lap_q, lap_d;
  logic [15:0]   cnt_all;
  logic          running;
  logic          tick_due;
  logic          at_max;
  logic          clr_pulse;

  assign cnt_all  = {cnt3, cnt2, cnt1, cnt0};
  assign running  = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick_due = running && (presc_q == c_pre_last);
  assign at_max   = (cnt_all == c_cnt_max);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    lap_d     = lap_q;
    clr_pulse = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (p_clr)     clr_pulse = 1'b1;
        else if (p_ss) state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (tick_due && at_max) begin
          state_d = ST_OVF;
        end else if (p_ss) begin
          state_d = ST_PAUSE;
        end else if (p_lap) begin
          state_d = ST_LAP;
          lap_d   = cnt_all;
        end
      end
      ST_LAP: begin
        if (tick_due && at_max) state_d = ST_OVF;
        else if (p_ss)          state_d = ST_PAUSE;
        else if (p_lap)         state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (p_clr) begin
          clr_pulse = 1'b1;
          state_d   = ST_IDLE;
        end else if (p_ss) begin
          state_d = ST_RUN;
        end
      end
      ST_OVF: begin
        if (p_clr) begin
          clr_pulse = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A suppressed tick at F999 leaves the prescaler parked at its last value.
    if (running) begin
      if (!tick_due)    presc_d = presc_q + 1'b1;
      else if (!at_max) presc_d = '0;
    end

    if (clr_pulse) begin
      presc_d = '0;
      lap_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
    end
  end

  assign cin0    = rst & tick_due & ~at_max;
  assign cnt_rst = rst & ~clr_pulse;

  assign {disp3, disp2, disp1, disp0} = (state_q == ST_LAP) ? lap_q : cnt_all;

  assign run_led = running;
  assign lap_led = (state_q == ST_LAP);
  assign ovf_led = (state_q == ST_OVF);

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_stopwatch_ctrl
// Brief   : Directed scoreboard bench for stopwatch_ctrl with a BCD counter model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int DB_CYCLES = 3;
  localparam int S_DISP = 0;
  localparam int S_LED  = 1;
  localparam int S_CIN  = 2;
  localparam int S_CRST = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  btn = 3'b000;
  logic [3:0]  cnt0, cnt1, cnt2, cnt3;
  logic        cin0, cnt_rst;
  logic [3:0]  disp0, disp1, disp2, disp3;
  logic        run_led, lap_led, ovf_led;
  logic        ld = 1'b0;
  logic [15:0] ld_val = 16'h0000;
  logic [15:0] cnt_q;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct {
    int          c;
    int          sel;
    logic [15:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];

  stopwatch_ctrl #(
    .TICK_DIV (TICK_DIV),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_ss (btn[0]),
    .btn_lap(btn[1]),
    .btn_clr(btn[2]),
    .cnt0   (cnt0),
    .cnt1   (cnt1),
    .cnt2   (cnt2),
    .cnt3   (cnt3),
    .cin0   (cin0),
    .cnt_rst(cnt_rst),
    .disp0  (disp0),
    .disp1  (disp1),
    .disp2  (disp2),
    .disp3  (disp3),
    .run_led(run_led),
    .lap_led(lap_led),
    .ovf_led(ovf_led)
  );

  assign {cnt3, cnt2, cnt1, cnt0} = cnt_q;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (r[11:8] != 4'd9) r[11:8] = r[11:8] + 4'd1;
        else begin
          r[11:8]  = 4'd0;
          r[15:12] = r[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // External digit4_counter stand-in: sync active-low clear, preload, BCD count.
  always @(posedge clk) begin
    if (!cnt_rst)  cnt_q <= 16'h0000;
    else if (ld)   cnt_q <= ld_val;
    else if (cin0) cnt_q <= bcd_inc(cnt_q);
  end

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_DISP:  return {disp3, disp2, disp1, disp0};
      S_LED:   return {13'd0, run_led, lap_led, ovf_led};
      S_CIN:   return {15'd0, cin0};
      default: return {15'd0, cnt_rst};
    endcase
  endfunction

  task automatic push(input int c, input int sel, input logic [15:0] v, input string tag);
    exp_t e;
    e.c = c; e.sel = sel; e.v = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic cin_win(input int a, input int b, input int first, input string tag);
    for (int c = a; c <= b; c++)
      push(c, S_CIN, {15'd0, (first >= 0 && c >= first && ((c - first) % TICK_DIV) == 0)}, tag);
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard consumer: pops every expectation due this cycle, mid-cycle.
  initial begin
    logic [15:0] o;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].c <= cyc) begin
          o = observe(sb[i].sel);
          n_vec++;
          assert (sb[i].c == cyc && o === sb[i].v) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d (due %0d): observed %h expected %h",
                   sb[i].tag, cyc, sb[i].c, o, sb[i].v);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and IDLE
    push(1, S_CRST, 16'h0, "rst_cnt_rst_low");
    go(2);
    rst = 1'b1;
    push(2, S_LED,  16'h0,    "rst_leds");
    push(2, S_DISP, 16'h0000, "rst_disp");
    push(2, S_CRST, 16'h1,    "rst_release_cnt_rst");
    cin_win(2, 9, -1, "idle_no_cin0");

    // Start: RUN six cycles after the raw edge, then a short glitch
    push(9,  S_LED, 16'h0, "ss_before_latency");
    push(10, S_LED, 16'h4, "ss_to_run");
    cin_win(10, 30, 13, "run_cin0_period");
    push(14, S_DISP, 16'h0001, "live_disp_1");
    push(22, S_DISP, 16'h0003, "live_disp_3");
    push(28, S_LED,  16'h4,    "glitch_ignored_a");
    push(30, S_LED,  16'h4,    "glitch_ignored_b");
    go(4);  btn[0] = 1'b1;
    go(14); btn[0] = 1'b0;
    go(20); btn[0] = 1'b1;
    go(22); btn[0] = 1'b0;

    // Lap freeze while ticking continues, then back to live display
    cin_win(31, 72, 13, "lap_cin0_continues");
    push(38, S_LED,  16'h4,    "pre_lap_run");
    push(38, S_DISP, 16'h0123, "pre_lap_live");
    push(39, S_LED,  16'h6,    "lap_leds");
    push(39, S_DISP, 16'h0123, "lap_frozen_a");
    push(45, S_DISP, 16'h0123, "lap_frozen_b");
    push(55, S_DISP, 16'h0123, "lap_frozen_c");
    push(55, S_LED,  16'h6,    "lap_still");
    push(56, S_LED,  16'h4,    "lap_to_run");
    push(56, S_DISP, 16'h0127, "relive_disp");
    push(66, S_DISP, 16'h0130, "relive_carry");
    go(33); btn[1] = 1'b1;
    go(37); ld_val = 16'h0123; ld = 1'b1;
    go(38); ld = 1'b0;
    go(43); btn[1] = 1'b0;
    go(50); btn[1] = 1'b1;
    go(60); btn[1] = 1'b0;

    // Pause with prescaler at 2, resume ticks on the first RUN cycle
    push(72, S_LED,  16'h4,    "pause_pending");
    push(73, S_LED,  16'h0,    "pause_leds");
    cin_win(73, 89, -1, "pause_no_cin0");
    push(73, S_DISP, 16'h0131, "pause_disp_a");
    push(88, S_DISP, 16'h0131, "pause_disp_b");
    push(90, S_LED,  16'h4,    "resume_run");
    cin_win(90, 105, 90, "resume_cin0");
    push(91, S_DISP, 16'h0132, "resume_disp_a");
    push(95, S_DISP, 16'h0133, "resume_disp_b");
    go(67); btn[0] = 1'b1;
    go(77); btn[0] = 1'b0;
    go(84); btn[0] = 1'b1;
    go(94); btn[0] = 1'b0;

    // Pause, clear, preload F998 and run into saturation
    push(105, S_LED,  16'h4,    "pause2_pending");
    push(106, S_LED,  16'h0,    "pause2_leds");
    cin_win(106, 127, -1, "pause2_idle_no_cin0");
    push(116, S_DISP, 16'h0135, "pause2_disp");
    push(116, S_CRST, 16'h1,    "clr_pre");
    push(117, S_CRST, 16'h0,    "clr_pulse");
    push(118, S_CRST, 16'h1,    "clr_post");
    push(118, S_LED,  16'h0,    "clr_idle");
    push(118, S_DISP, 16'h0000, "clr_disp");
    go(100); btn[0] = 1'b1;
    go(110); btn[0] = 1'b0;
    go(112); btn[2] = 1'b1;
    go(121); ld_val = 16'hF998; ld = 1'b1;
    go(122); ld = 1'b0; btn[2] = 1'b0; btn[0] = 1'b1;
    push(127, S_LED,  16'h0,    "ovf_pre_run");
    push(128, S_LED,  16'h4,    "ovf_run");
    cin_win(128, 134, 131, "ovf_last_tick");
    push(135, S_CIN,  16'h0,    "max_tick_suppressed");
    push(132, S_DISP, 16'hF999, "ovf_disp_a");
    push(135, S_LED,  16'h4,    "ovf_pending");
    push(136, S_LED,  16'h1,    "ovf_leds");
    cin_win(136, 161, -1, "ovf_idle_no_cin0");
    push(136, S_DISP, 16'hF999, "ovf_disp_b");
    push(145, S_DISP, 16'hF999, "ovf_hold");
    push(144, S_LED,  16'h1,    "ovf_ss_ignored_a");
    push(150, S_LED,  16'h1,    "ovf_ss_ignored_b");
    push(150, S_CRST, 16'h1,    "ovf_clr_pre");
    push(151, S_CRST, 16'h0,    "ovf_clr_pulse");
    push(152, S_CRST, 16'h1,    "ovf_clr_post");
    push(152, S_LED,  16'h0,    "ovf_clr_idle");
    push(152, S_DISP, 16'h0000, "ovf_clr_disp");
    go(132); btn[0] = 1'b0;
    go(138); btn[0] = 1'b1;
    go(146); btn[2] = 1'b1;
    go(148); btn[0] = 1'b0;
    go(156); btn[2] = 1'b0;

    // Simultaneous clr+ss in PAUSE: clear wins
    cin_win(162, 167, -1, "u_idle_no_cin0");
    push(170, S_LED, 16'h4, "u_run");
    cin_win(168, 183, 171, "u_run_cin0");
    cin_win(184, 209, -1, "u_pause_no_cin0");
    push(184, S_LED,  16'h0,    "u_pause");
    push(190, S_DISP, 16'h0004, "u_pause_disp_a");
    push(198, S_DISP, 16'h0004, "u_pause_disp_b");
    push(199, S_CRST, 16'h0,    "both_clr_pulse");
    push(200, S_CRST, 16'h1,    "both_clr_post");
    push(200, S_LED,  16'h0,    "both_not_run");
    push(200, S_DISP, 16'h0000, "both_cleared");
    push(205, S_LED,  16'h0,    "both_idle_hold");
    go(162); btn[0] = 1'b1;
    go(172); btn[0] = 1'b0;
    go(178); btn[0] = 1'b1;
    go(188); btn[0] = 1'b0;
    go(194); btn = 3'b101;
    go(204); btn = 3'b000;

    // Reset while in LAP
    cin_win(210, 215, -1, "v_idle_no_cin0");
    push(216, S_LED, 16'h4, "v_run");
    cin_win(216, 225, 219, "v_run_cin0");
    push(224, S_LED,  16'h6,    "v_lap");
    push(224, S_DISP, 16'h0001, "v_lap_disp");
    push(226, S_CIN,  16'h0,    "v_rst_cin0_a");
    push(227, S_CIN,  16'h0,    "v_rst_cin0_b");
    push(226, S_CRST, 16'h0,    "v_rst_cnt_rst_a");
    push(227, S_CRST, 16'h0,    "v_rst_cnt_rst_b");
    push(228, S_LED,  16'h0,    "v_rst_leds");
    push(228, S_DISP, 16'h0000, "v_rst_disp");
    push(228, S_CRST, 16'h1,    "v_rst_release");
    cin_win(228, 240, -1, "v_post_rst_no_cin0");
    push(240, S_LED,  16'h0,    "v_post_rst_idle");
    go(210); btn[0] = 1'b1;
    go(218); btn[1] = 1'b1;
    go(220); btn[0] = 1'b0;
    go(226); rst = 1'b0;
    go(228); rst = 1'b1; btn[1] = 1'b0;

    go(250);
    n_vec++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
